// File: rtl/reg8_scan16.sv
// Eight-entry register file feeding an 8-way selector, plus the registered select
// generator (direct host address or handshaked 0..7 scan).
module reg8_scan16 #(
  parameter int              WIDTH     = 16,
  parameter logic [WIDTH-1:0] RESET_VAL = 16'h0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [2:0]       addr,
  input  logic [WIDTH-1:0] in,
  output logic [WIDTH-1:0] q_a,
  output logic [WIDTH-1:0] q_b,
  output logic [WIDTH-1:0] q_c,
  output logic [WIDTH-1:0] q_d,
  output logic [WIDTH-1:0] q_e,
  output logic [WIDTH-1:0] q_f,
  output logic [WIDTH-1:0] q_g,
  output logic [WIDTH-1:0] q_h,
  input  logic             scan_start,
  input  logic             sel_ready,
  output logic [2:0]       sel,
  output logic             sel_valid,
  output logic             scan_busy,
  output logic             scan_done
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  logic [WIDTH-1:0] regs_r [8];

  // Register file: writes land in any FSM state, including mid-scan.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < 8; i++) begin
        regs_r[i] <= RESET_VAL;
      end
    end else if (load) begin
      regs_r[addr] <= in;
    end
  end

  assign q_a = regs_r[0];
  assign q_b = regs_r[1];
  assign q_c = regs_r[2];
  assign q_d = regs_r[3];
  assign q_e = regs_r[4];
  assign q_f = regs_r[5];
  assign q_g = regs_r[6];
  assign q_h = regs_r[7];

  // Select generator FSM; all handshake outputs are registered here.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_r   <= IDLE;
      sel       <= 3'd0;
      sel_valid <= 1'b0;
      scan_busy <= 1'b0;
      scan_done <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          scan_done <= 1'b0;
          if (scan_start) begin
            state_r   <= SCAN;
            sel       <= 3'd0;
            sel_valid <= 1'b1;
            scan_busy <= 1'b1;
          end else begin
            sel       <= addr;
            sel_valid <= 1'b0;
            scan_busy <= 1'b0;
          end
        end
        SCAN: begin
          if (sel_valid && sel_ready) begin
            if (sel == 3'd7) begin
              // Last index accepted: sel holds at 7 through DONE, never wraps.
              state_r   <= DONE;
              sel_valid <= 1'b0;
              scan_busy <= 1'b0;
              scan_done <= 1'b1;
            end else begin
              sel <= sel + 3'd1;
            end
          end else begin
            sel <= sel;
          end
        end
        DONE: begin
          state_r   <= IDLE;
          sel       <= addr;
          sel_valid <= 1'b0;
          scan_busy <= 1'b0;
          scan_done <= 1'b0;
        end
        default: begin
          state_r   <= IDLE;
          sel       <= 3'd0;
          sel_valid <= 1'b0;
          scan_busy <= 1'b0;
          scan_done <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_reg8_scan16.sv
// Randomized + directed bench for reg8_scan16 against a scan-index reference model.
module tb_reg8_scan16;

  logic        clk;
  logic        reset;
  logic        load;
  logic [2:0]  addr;
  logic [15:0] in;
  logic [15:0] q_a, q_b, q_c, q_d, q_e, q_f, q_g, q_h;
  logic        scan_start;
  logic        sel_ready;
  logic [2:0]  sel;
  logic        sel_valid;
  logic        scan_busy;
  logic        scan_done;

  logic [15:0] q [8];
  assign q[0] = q_a;
  assign q[1] = q_b;
  assign q[2] = q_c;
  assign q[3] = q_d;
  assign q[4] = q_e;
  assign q[5] = q_f;
  assign q[6] = q_g;
  assign q[7] = q_h;

  reg8_scan16 dut (
    .clk(clk), .reset(reset), .load(load), .addr(addr), .in(in),
    .q_a(q_a), .q_b(q_b), .q_c(q_c), .q_d(q_d),
    .q_e(q_e), .q_f(q_f), .q_g(q_g), .q_h(q_h),
    .scan_start(scan_start), .sel_ready(sel_ready),
    .sel(sel), .sel_valid(sel_valid), .scan_busy(scan_busy), .scan_done(scan_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks_cnt   = 0;
  int failures_cnt = 0;

  // Reference: register contents, presented select, and scan position
  // (-1 = not scanning, 0..7 = index on offer, 8 = completion cycle).
  logic [15:0] m_mem [8];
  logic [2:0]  m_sel;
  int          m_idx;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks_cnt++;
    if (obs !== exp) begin
      failures_cnt++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 8; i++) m_mem[i] = 16'h0000;
    m_sel = 3'd0;
    m_idx = -1;
  endtask

  task automatic model_edge();
    if (load) m_mem[addr] = in;
    if (m_idx < 0) begin
      if (scan_start) begin
        m_idx = 0;
        m_sel = 3'd0;
      end else begin
        m_sel = addr;
      end
    end else if (m_idx == 8) begin
      m_idx = -1;
      m_sel = addr;
    end else if (sel_ready) begin
      m_idx = m_idx + 1;
      if (m_idx < 8) m_sel = m_idx[2:0];
    end
  endtask

  task automatic check_all();
    for (int i = 0; i < 8; i++) check_val($sformatf("q%0d", i), {16'h0000, q[i]}, {16'h0000, m_mem[i]});
    check_val("sel", {29'd0, sel}, {29'd0, m_sel});
    check_val("sel_valid", {31'd0, sel_valid}, {31'd0, (m_idx >= 0 && m_idx <= 7)});
    check_val("scan_busy", {31'd0, scan_busy}, {31'd0, (m_idx >= 0 && m_idx <= 7)});
    check_val("scan_done", {31'd0, scan_done}, {31'd0, (m_idx == 8)});
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    @(negedge clk);
    check_all();
  endtask

  // Advance with sel_ready high until the model presents index k (bounded).
  task automatic run_to_index(input int k);
    int n;
    n = 0;
    sel_ready = 1'b1;
    while (!(m_idx == k) && n < 20) begin
      step();
      n++;
    end
    if (m_idx != k) check_val("run_to_index_timeout", 32'(m_idx), 32'(k));
  endtask

  initial begin
    reset = 1'b1; load = 1'b0; addr = 3'd0; in = 16'h0000;
    scan_start = 1'b0; sel_ready = 1'b0;
    model_reset();
    #1 check_all();
    @(negedge clk);
    reset = 1'b0;

    // Write each register with a distinct pattern.
    for (int k = 0; k < 8; k++) begin
      load = 1'b1; addr = 3'(k); in = 16'h1111 * 16'(k + 1);
      step();
      check_val("write_q", {16'h0000, q[k]}, {16'h0000, 16'h1111 * 16'(k + 1)});
    end
    load = 1'b0;

    // Direct mode: sel follows addr with one-cycle latency.
    addr = 3'd5; step(); check_val("direct5", {29'd0, sel}, 32'd5);
    addr = 3'd2; step(); check_val("direct2", {29'd0, sel}, 32'd2);
    addr = 3'd7; step(); check_val("direct7", {29'd0, sel}, 32'd7);

    // Full-throughput scan.
    sel_ready = 1'b1; scan_start = 1'b1; addr = 3'd6;
    step();
    scan_start = 1'b0;
    check_val("scan_first", {29'd0, sel}, 32'd0);
    for (int i = 1; i < 8; i++) begin
      step();
      check_val("scan_seq", {29'd0, sel}, 32'(i));
      check_val("scan_valid", {31'd0, sel_valid}, 32'd1);
    end
    step(); check_val("scan_done_9th", {31'd0, scan_done}, 32'd1);
    step(); check_val("done_one_cycle", {31'd0, scan_done}, 32'd0);
    check_val("back_to_direct", {29'd0, sel}, 32'd6);

    // Backpressure at index 3 with an ignored scan_start.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    run_to_index(3);
    sel_ready = 1'b0;
    for (int i = 0; i < 3; i++) begin
      scan_start = (i == 1);
      step();
      check_val("stall_sel", {29'd0, sel}, 32'd3);
      check_val("stall_valid", {31'd0, sel_valid}, 32'd1);
    end
    scan_start = 1'b0; sel_ready = 1'b1;
    step(); check_val("resume_sel", {29'd0, sel}, 32'd4);
    run_to_index(-1);

    // Write to the held index mid-scan.
    scan_start = 1'b1; step(); scan_start = 1'b0;
    run_to_index(2);
    sel_ready = 1'b0; load = 1'b1; addr = 3'd2; in = 16'hBEEF;
    step();
    load = 1'b0;
    check_val("wds_q_c", {16'h0000, q_c}, 32'h0000BEEF);
    check_val("wds_sel", {29'd0, sel}, 32'd2);
    step();
    check_val("wds_hold", {29'd0, sel}, 32'd2);
    run_to_index(-1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      load       = ($urandom_range(0, 3) == 0);
      addr       = 3'($urandom_range(0, 7));
      in         = 16'($urandom);
      scan_start = ($urandom_range(0, 7) == 0);
      sel_ready  = ($urandom_range(0, 9) < 7);
      step();
    end
    load = 1'b0; scan_start = 1'b0;

    // Asynchronous reset mid-scan at index 4.
    run_to_index(-1);
    scan_start = 1'b1; step(); scan_start = 1'b0;
    run_to_index(4);
    #2 reset = 1'b1;
    model_reset();
    #1 check_all();
    check_val("rst_sel", {29'd0, sel}, 32'd0);
    @(negedge clk);
    reset = 1'b0; addr = 3'd3; sel_ready = 1'b1;
    step();
    check_val("post_rst_idle", {29'd0, sel}, 32'd3);

    $display("TB_RESULT checks=%0d failures=%0d", checks_cnt, failures_cnt);
    $finish;
  end

endmodule

// File: doc/reg8_scan16.md
Name: reg8_scan16

Overview:
- Upstream feeder for the 8-way 16-bit selector.
- Holds eight 16-bit registers whose outputs drive the selector's eight data inputs a..h.
- Generates the registered 3-bit select that drives the selector's sel input.
- Two select modes:
  - Direct mode: sel follows a host address.
  - Scan mode: sel steps 0..7 under a valid/ready handshake, so a downstream consumer reads every register in order through the selector.

Parameters:
- WIDTH, 16, bit width of each register and of the write data.
- RESET_VAL, 16'h0000, value loaded into all eight registers on reset.

Ports:
- clk  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- load  input  1  write enable for register file.
- addr  input  3  write address; also the direct-mode select source.
- in  input  WIDTH  write data.
- q_a  output  WIDTH  register 0 contents, drives selector input a.
- q_b .. q_h  output  WIDTH each  registers 1..7, drive selector inputs b..h.
- scan_start  input  1  request a full 0..7 scan (sampled in IDLE only).
- sel_ready  input  1  consumer accepts the current scan index.
- sel  output  3  registered select to the selector.
- sel_valid  output  1  high while a scan index is presented.
- scan_busy  output  1  high in SCAN state.
- scan_done  output  1  one-cycle pulse after index 7 is accepted.

Behaviour:
- Reset (asynchronous, any state):
  - All q_* are set to RESET_VAL.
  - sel=0, sel_valid=0, scan_busy=0, scan_done=0.
  - FSM goes to IDLE.
- Register file:
  - On a clk edge with load=1, register[addr] <= in.
  - Write data is visible on q_* the following cycle.
  - Writes are accepted in every FSM state, including mid-scan.
- FSM states: IDLE, SCAN, DONE.
- IDLE:
  - Every cycle, sel <= addr, so sel has one-cycle latency from addr.
  - sel_valid=0, scan_busy=0.
  - scan_start=1 moves to SCAN, sel <= 0, sel_valid <= 1, scan_busy <= 1.
  - scan_start takes priority over the addr copy in that cycle.
- SCAN:
  - sel_valid=1.
  - sel holds while sel_ready=0; no timeout.
  - On sel_valid && sel_ready with sel<7: sel <= sel+1.
  - On sel_valid && sel_ready with sel==7: go to DONE, sel_valid <= 0, scan_busy <= 0, scan_done <= 1.
  - sel never wraps from 7 to 0 inside a scan.
  - scan_start is ignored in SCAN.
- DONE:
  - Lasts exactly one cycle with scan_done=1.
  - Returns to IDLE, with scan_done <= 0 and sel <= addr.
  - scan_start is ignored in DONE; a new scan needs scan_start asserted in IDLE.
- Write to the currently presented index during SCAN:
  - The new value appears on q_* one cycle after the write edge.
  - The consumer sees the updated value on any later cycle the index is still held.
- Throughput: with sel_ready tied high, indices 0..7 occupy 8 consecutive cycles, followed by 1 DONE cycle.
- All outputs are registered; there are no combinational paths from inputs to outputs.

Test Plan:
- Reset mid-scan at sel=4 -> same cycle: all q_*=0000, sel=0, sel_valid=0, scan_busy=0; next state IDLE.
- Write each register: load=1, addr=k, in=16'h1111*(k+1) for k=0..7 -> q_a=1111 ... q_h=8888 one cycle after each write; other registers unchanged.
- Direct mode: addr sequence 5,2,7 in IDLE -> sel reads 5,2,7, each delayed by one cycle.
- Scan with sel_ready=1 -> sel=0..7 on 8 consecutive cycles with sel_valid=1; scan_done=1 on the 9th cycle only; then IDLE.
- Backpressure: sel_ready=0 for 3 cycles at sel=3 -> sel stays 3 with sel_valid=1; scan_start pulsed during the stall is ignored; the scan resumes to 4 after sel_ready rises.
- Write-during-scan: while sel=2 is held, write addr=2 in=16'hBEEF -> q_c=BEEF on the next cycle, and sel stays 2 until accepted.
